// File: rtl/controle_motores.sv
// Dual H-bridge motor driver for the wall-following robot: decodes the
// avancar/girar command, soft-starts the PWM duty and brakes between modes.
module controle_motores #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned DUTY_FRENTE = 200,
   parameter int unsigned DUTY_GIRO   = 120,
   parameter int unsigned RAMP_STEP   = 40,
   parameter int unsigned DEADTIME    = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic avancar,
   input  logic girar,
   output logic pwm_esq,
   output logic pwm_dir,
   output logic sentido_esq,
   output logic sentido_dir,
   output logic em_regime
);

   localparam int unsigned SUM_W  = PWM_BITS + 1;
   localparam int unsigned DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

   localparam logic [PWM_BITS-1:0] CNT_MAX     = '1;
   localparam logic [SUM_W-1:0]    STEP        = SUM_W'(RAMP_STEP);
   localparam logic [SUM_W-1:0]    ALVO_FRENTE = SUM_W'(DUTY_FRENTE);
   localparam logic [SUM_W-1:0]    ALVO_GIRO   = SUM_W'(DUTY_GIRO);
   localparam logic [DEAD_W-1:0]   DEAD_LAST   = DEAD_W'(DEADTIME - 1);

   typedef enum logic [1:0] {
      PARADO = 2'd0,
      FRENTE = 2'd1,
      GIRO   = 2'd2,
      FREIO  = 2'd3
   } estado_t;

   estado_t             estado_q, estado_d;
   estado_t             cmd_q, cmd_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [DEAD_W-1:0]   dead_q, dead_d;
   logic                sent_esq_q, sent_esq_d;
   logic                sent_dir_q, sent_dir_d;
   logic                pwm_q, pwm_d;
   logic                em_q, em_d;

   logic                movendo_d;
   logic                entrada_d;
   logic [SUM_W-1:0]    alvo_d;
   logic [SUM_W-1:0]    soma;

   // State register and all datapath flops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= PARADO;
         cmd_q      <= PARADO;
         cnt_q      <= '0;
         duty_q     <= '0;
         dead_q     <= '0;
         sent_esq_q <= 1'b1;
         sent_dir_q <= 1'b1;
         pwm_q      <= 1'b0;
         em_q       <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cmd_q      <= cmd_d;
         cnt_q      <= cnt_d;
         duty_q     <= duty_d;
         dead_q     <= dead_d;
         sent_esq_q <= sent_esq_d;
         sent_dir_q <= sent_dir_d;
         pwm_q      <= pwm_d;
         em_q       <= em_d;
      end
   end

   // Command decode; the illegal 11 pair falls into the safe stop
   always_comb begin
      cmd_d = PARADO;
      unique case ({avancar, girar})
         2'b10:   cmd_d = FRENTE;
         2'b01:   cmd_d = GIRO;
         default: cmd_d = PARADO;
      endcase
   end

   // Next-state logic; FREIO always runs its full dead time
   always_comb begin
      estado_d = estado_q;
      unique case (estado_q)
         PARADO: if (cmd_q == FRENTE || cmd_q == GIRO) estado_d = cmd_q;
         FRENTE: if (cmd_q != FRENTE) estado_d = FREIO;
         GIRO:   if (cmd_q != GIRO) estado_d = FREIO;
         FREIO:  if (dead_q == DEAD_LAST) estado_d = cmd_q;
         default: estado_d = PARADO;
      endcase
   end

   // Datapath and registered outputs, computed from next-cycle values so the
   // PWM flop lines up with the counter/duty flops of the same cycle
   always_comb begin
      cnt_d      = cnt_q + PWM_BITS'(1);
      duty_d     = '0;
      dead_d     = '0;
      sent_esq_d = sent_esq_q;
      sent_dir_d = sent_dir_q;

      movendo_d = (estado_d == FRENTE) || (estado_d == GIRO);
      entrada_d = movendo_d && (estado_d != estado_q);
      alvo_d    = (estado_d == GIRO) ? ALVO_GIRO : ALVO_FRENTE;
      soma      = {1'b0, duty_q} + STEP;

      if (estado_q == FREIO && estado_d == FREIO) begin
         dead_d = dead_q + DEAD_W'(1);
      end

      // Ramp only while staying in the same motion state; exits force duty 0
      if (movendo_d && !entrada_d) begin
         duty_d = duty_q;
         if (cnt_q == CNT_MAX) begin
            duty_d = (soma > alvo_d) ? PWM_BITS'(alvo_d) : PWM_BITS'(soma);
         end
      end

      if (entrada_d) begin
         sent_esq_d = 1'b1;
         sent_dir_d = (estado_d == FRENTE);
      end

      pwm_d = movendo_d && (cnt_d < duty_d);
      em_d  = movendo_d && ({1'b0, duty_d} == alvo_d);
   end

   assign pwm_esq     = pwm_q;
   assign pwm_dir     = pwm_q;
   assign sentido_esq = sent_esq_q;
   assign sentido_dir = sent_dir_q;
   assign em_regime   = em_q;

endmodule

// File: tb/tb_controle_motores.sv
// Directed bench for controle_motores: reset, ramps, braking, illegal command
// and asynchronous reset mid-ramp. Outputs are sampled on the falling edge.
module tb_controle_motores;

   logic clock   = 1'b0;
   logic reset   = 1'b1;
   logic avancar = 1'b0;
   logic girar   = 1'b0;
   logic pwm_esq, pwm_dir, sentido_esq, sentido_dir, em_regime;

   int errors = 0;
   int checks = 0;

   controle_motores dut (
      .clock       (clock),
      .reset       (reset),
      .avancar     (avancar),
      .girar       (girar),
      .pwm_esq     (pwm_esq),
      .pwm_dir     (pwm_dir),
      .sentido_esq (sentido_esq),
      .sentido_dir (sentido_dir),
      .em_regime   (em_regime)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive(input logic a, input logic g);
      avancar = a;
      girar   = g;
   endtask

   // Returns on the first sample where the PWM has just gone high
   task automatic wait_rise(output bit to);
      int n;
      n  = 0;
      to = 1'b0;
      while (pwm_esq !== 1'b0 && n < 600) begin @(negedge clock); n++; end
      while (pwm_esq !== 1'b1 && n < 1200) begin @(negedge clock); n++; end
      if (pwm_esq !== 1'b1) to = 1'b1;
   endtask

   // Length of the next high pulse, em_regime at its first sample, wheel match
   task automatic measure_run(output int len, output bit em_first,
                              output bit lr_ok, output bit to);
      wait_rise(to);
      em_first = em_regime;
      lr_ok    = 1'b1;
      len      = 0;
      while (pwm_esq === 1'b1 && len < 300) begin
         if (pwm_dir !== pwm_esq) lr_ok = 1'b0;
         len++;
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      int bad;
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({pwm_esq, pwm_dir, em_regime, sentido_esq, sentido_dir} !== 5'b00011) begin
         errors++;
         $display("FAIL reset_async: outputs=%b expected 00011",
                  {pwm_esq, pwm_dir, em_regime, sentido_esq, sentido_dir});
      end
      repeat (5) @(negedge clock);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if ({pwm_esq, pwm_dir, em_regime, sentido_esq, sentido_dir} !== 5'b00011) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_parado: %0d bad samples, expected 0", bad);
      end
   endtask

   task automatic test_ramp_frente();
      int  exp_len [6];
      bit  exp_em  [6];
      int  len;
      bit  em, lr, to;
      exp_len = '{40, 80, 120, 160, 200, 200};
      exp_em  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      drive(1'b1, 1'b0);
      repeat (2) @(negedge clock);
      checks++;
      if ({sentido_esq, sentido_dir, em_regime} !== 3'b110) begin
         errors++;
         $display("FAIL frente_entry: sentido/em=%b expected 110",
                  {sentido_esq, sentido_dir, em_regime});
      end
      for (int i = 0; i < 6; i++) begin
         measure_run(len, em, lr, to);
         checks++;
         if (to || len != exp_len[i]) begin
            errors++;
            $display("FAIL frente_run%0d: high=%0d expected %0d (timeout=%0d)",
                     i, len, exp_len[i], to);
         end
         checks++;
         if (em !== exp_em[i] || !lr) begin
            errors++;
            $display("FAIL frente_em%0d: em=%0d lr_ok=%0d expected em=%0d lr_ok=1",
                     i, em, lr, exp_em[i]);
         end
      end
   endtask

   task automatic test_frente_to_giro();
      int  exp_len [4];
      bit  exp_em  [4];
      int  n, low, len;
      bit  em, lr, to;
      exp_len = '{40, 80, 120, 120};
      exp_em  = '{1'b0, 1'b0, 1'b1, 1'b1};
      wait_rise(to);
      drive(1'b0, 1'b1);
      n   = 0;
      low = 0;
      do begin
         @(negedge clock);
         n++;
         if (sentido_dir === 1'b1 && pwm_esq === 1'b0 && pwm_dir === 1'b0) low++;
      end while (sentido_dir !== 1'b0 && n < 200);
      checks++;
      if (to || n != 34 || low != 32) begin
         errors++;
         $display("FAIL giro_brake: switch_at=%0d low=%0d expected 34/32 (timeout=%0d)",
                  n, low, to);
      end
      checks++;
      if ({sentido_esq, sentido_dir} !== 2'b10) begin
         errors++;
         $display("FAIL giro_sentido: %b expected 10", {sentido_esq, sentido_dir});
      end
      for (int i = 0; i < 4; i++) begin
         measure_run(len, em, lr, to);
         checks++;
         if (to || len != exp_len[i]) begin
            errors++;
            $display("FAIL giro_run%0d: high=%0d expected %0d (timeout=%0d)",
                     i, len, exp_len[i], to);
         end
         checks++;
         if (em !== exp_em[i] || !lr) begin
            errors++;
            $display("FAIL giro_em%0d: em=%0d lr_ok=%0d expected em=%0d lr_ok=1",
                     i, em, lr, exp_em[i]);
         end
      end
   endtask

   task automatic test_freio_toggle();
      int n, low, bad;
      bit to;
      // Toggling during the brake, ending on forward: full dead time still applies
      wait_rise(to);
      drive(1'b0, 1'b0);
      n   = 0;
      low = 0;
      do begin
         @(negedge clock);
         n++;
         if (sentido_dir === 1'b0 && pwm_esq === 1'b0 && pwm_dir === 1'b0) low++;
         if (n == 2)  drive(1'b1, 1'b0);
         if (n == 7)  drive(1'b0, 1'b0);
         if (n == 12) drive(1'b0, 1'b1);
         if (n == 17) drive(1'b1, 1'b0);
      end while (sentido_dir !== 1'b1 && n < 200);
      checks++;
      if (to || n != 34 || low != 32) begin
         errors++;
         $display("FAIL toggle_brake: switch_at=%0d low=%0d expected 34/32 (timeout=%0d)",
                  n, low, to);
      end
      // Same toggling from FRENTE, ending on stop: PWM never comes back
      drive(1'b0, 1'b0);
      bad = 0;
      for (int i = 1; i <= 600; i++) begin
         @(negedge clock);
         if ({pwm_esq, pwm_dir, em_regime, sentido_esq, sentido_dir} !== 5'b00011) bad++;
         if (i == 2)  drive(1'b1, 1'b0);
         if (i == 7)  drive(1'b0, 1'b0);
         if (i == 12) drive(1'b0, 1'b1);
         if (i == 17) drive(1'b0, 1'b0);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL toggle_parado: %0d bad samples, expected 0", bad);
      end
   endtask

   task automatic test_illegal_cmd();
      int n, bad;
      bit to;
      drive(1'b1, 1'b0);
      n = 0;
      while (em_regime !== 1'b1 && n < 2000) begin @(negedge clock); n++; end
      checks++;
      if (em_regime !== 1'b1) begin
         errors++;
         $display("FAIL illegal_setup: em_regime=%b expected 1 within 2000 cycles", em_regime);
      end
      wait_rise(to);
      drive(1'b1, 1'b1);
      @(negedge clock);
      checks++;
      if (to || pwm_esq !== 1'b1) begin
         errors++;
         $display("FAIL illegal_latency: pwm=%b expected 1 one cycle after 11 (timeout=%0d)",
                  pwm_esq, to);
      end
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         if ({pwm_esq, pwm_dir, em_regime} !== 3'b000) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL illegal_stop: %0d samples with PWM/em high, expected 0", bad);
      end
      // Now in PARADO: a rotate command enters GIRO after two edges
      drive(1'b0, 1'b1);
      @(negedge clock);
      checks++;
      if (sentido_dir !== 1'b1) begin
         errors++;
         $display("FAIL parado_giro_early: sentido_dir=%b expected 1", sentido_dir);
      end
      @(negedge clock);
      checks++;
      if (sentido_dir !== 1'b0) begin
         errors++;
         $display("FAIL parado_giro_entry: sentido_dir=%b expected 0", sentido_dir);
      end
      drive(1'b0, 1'b0);
      repeat (60) @(negedge clock);
   endtask

   task automatic test_reset_mid_ramp();
      int exp_len [2];
      int len, bad;
      bit em, lr, to;
      exp_len = '{40, 80};
      drive(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         measure_run(len, em, lr, to);
         checks++;
         if (to || len != exp_len[i]) begin
            errors++;
            $display("FAIL midramp_run%0d: high=%0d expected %0d (timeout=%0d)",
                     i, len, exp_len[i], to);
         end
      end
      wait_rise(to);
      repeat (5) @(negedge clock);
      checks++;
      if (to || pwm_esq !== 1'b1) begin
         errors++;
         $display("FAIL midramp_high: pwm=%b expected 1 before reset", pwm_esq);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({pwm_esq, pwm_dir, em_regime, sentido_esq, sentido_dir} !== 5'b00011) begin
         errors++;
         $display("FAIL midramp_async: outputs=%b expected 00011",
                  {pwm_esq, pwm_dir, em_regime, sentido_esq, sentido_dir});
      end
      bad = 0;
      repeat (3) begin
         @(negedge clock);
         if ({pwm_esq, pwm_dir} !== 2'b00) bad++;
      end
      reset = 1'b1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midramp_hold: %0d samples with PWM high in reset, expected 0", bad);
      end
      measure_run(len, em, lr, to);
      checks++;
      if (to || len != 40 || em !== 1'b0 || !lr) begin
         errors++;
         $display("FAIL midramp_restart: high=%0d em=%0d lr_ok=%0d expected 40/0/1 (timeout=%0d)",
                  len, em, lr, to);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_frente();
      test_frente_to_giro();
      test_freio_toggle();
      test_illegal_cmd();
      test_reset_mid_ramp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/controle_motores.md
Name: controle_motores

Overview:
- Downstream stage of the wall-following FSM.
- Consumes that FSM's `avancar`/`girar` command pair and drives two DC-motor H-bridges (left/right wheel) with PWM and direction signals.
- Adds a duty-cycle soft-start ramp and a braking dead-time before any direction or mode change, so the bridges never reverse under load.

Parameters:
- PWM_BITS, 8: PWM counter width; period = 2^PWM_BITS clocks.
- DUTY_FRENTE, 200: target duty (counts) in forward mode.
- DUTY_GIRO, 120: target duty (counts) in rotate mode.
- RAMP_STEP, 40: duty increment applied once per PWM period.
- DEADTIME, 32: braking cycles (PWM forced low) between motion modes; must be ≥1.

Ports:
- clock, input, 1: system clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- avancar, input, 1: forward command from wall-following FSM.
- girar, input, 1: rotate command from wall-following FSM.
- pwm_esq, output, 1: left-wheel PWM.
- pwm_dir, output, 1: right-wheel PWM.
- sentido_esq, output, 1: left-wheel direction (1 = forward).
- sentido_dir, output, 1: right-wheel direction (1 = forward).
- em_regime, output, 1: motion state active and duty equals target.

Behaviour:
- Reset (reset=0, asynchronous, also mid-operation), all applied immediately:
  - pwm_esq=pwm_dir=0, em_regime=0, sentido_esq=sentido_dir=1.
  - state=PARADO, duty=0, PWM counter=0, dead counter=0, cmd_q=PARADO.
- Command decode, registered into cmd_q each rising edge (1-cycle latency):
  - 10 -> FRENTE; 01 -> GIRO; 00 -> PARADO.
  - 11 (illegal) -> PARADO (safe stop).
- PWM counter: free-running 0..2^PWM_BITS-1, wraps to 0; runs in every state.
- FSM acts on cmd_q. States PARADO, FRENTE, GIRO, FREIO:
  - PARADO:
    - cmd_q=FRENTE -> FRENTE; cmd_q=GIRO -> GIRO; else stay.
    - On entry to FRENTE/GIRO: duty=0; direction outputs set the same edge.
  - FRENTE:
    - cmd_q≠FRENTE -> FREIO; otherwise stay.
  - GIRO:
    - cmd_q≠GIRO -> FREIO; otherwise stay.
  - FREIO:
    - duty=0 and both PWM low.
    - Dead counter counts 0..DEADTIME-1.
    - At DEADTIME-1: go to cmd_q's state (PARADO, FRENTE or GIRO).
    - Command changes during FREIO do not shorten it.
- Direction outputs, updated only on entry to a motion state, held in PARADO/FREIO:
  - FRENTE: sentido_esq=1, sentido_dir=1.
  - GIRO: sentido_esq=1, sentido_dir=0 (rotate right in place; wall kept on left).
- Ramp (FRENTE/GIRO only):
  - When counter = 2^PWM_BITS-1: duty <= min(duty+RAMP_STEP, target).
  - Sum computed in PWM_BITS+1 bits; no wrap.
- PWM outputs (registered):
  - In a motion state: pwm_esq = pwm_dir = (counter < duty).
  - In PARADO/FREIO: 0.
  - duty=0 gives constant low.
- em_regime (registered): 1 iff state ∈ {FRENTE, GIRO} and duty = target.
- Simultaneous events:
  - Ramp update and exit to FREIO on the same edge: exit wins, duty=0.
  - Reset overrides everything.

Test Plan:
1. Reset low 5 cycles, then release, avancar=girar=0 for 1000 cycles -> both PWM stay 0, sentido 1/1, em_regime 0.
2. avancar=1 held from PARADO -> FRENTE 2 edges later, sentido 1/1, duty ramps 40, 80, 120, 160, 200 at successive period ends; em_regime rises after 5th wrap; steady PWM high 200 of 256 cycles on both wheels.
3. In FRENTE steady, switch to girar=1 -> PWM low exactly 32 cycles (FREIO), then GIRO with sentido_dir=0, duty 40, 80, 120, em_regime after 3 wraps, high 120 of 256.
4. In FREIO, toggle commands (10, 00, 01) then hold 00 -> FREIO still lasts 32 cycles; then PARADO, PWM stays 0.
5. avancar=girar=1 from FRENTE -> treated as PARADO: FREIO 32 cycles then PARADO, PWM 0.
6. Drop reset mid-ramp (duty=120) asynchronously between edges -> outputs 0 and sentido 1/1 immediately; after release and avancar=1 the ramp restarts from 0.
